// File: rtl/xc_ctrl_pkg.sv
// Shared types and defaults for the correlator integration controller,
// its readout path and the packetizer.
package xc_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_INTEGRATE,
    ST_FREEZE,
    ST_READOUT
  } xc_state_e;

  localparam int unsigned XC_TICK_WIDTH     = 32;
  localparam int unsigned XC_WINDOW_WIDTH   = 16;
  localparam int unsigned XC_CLEAR_CYCLES   = 2;
  localparam int unsigned XC_FREEZE_CYCLES  = 2;
  localparam int unsigned XC_TIMEOUT_CYCLES = 65535;

  // Bits needed to hold n-1, i.e. the load value of an n-cycle phase.
  function automatic int unsigned xc_cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/xc_cycle_counter.sv
// Loadable down-counter; o_tc is high while the count is zero. The count
// saturates at zero, so it holds terminal count until reloaded.
module xc_cycle_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_value,
  input  logic             i_dec,
  output logic             o_tc
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_value;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - WIDTH'(1);
    end
  end

  assign o_tc = (r_count == '0);

endmodule

// File: rtl/correlator_integration_ctrl.sv
// Sequences the cross-correlator through clear / integrate / freeze / readout
// windows with double-buffered configuration applied at each CLEAR entry.
module correlator_integration_ctrl
  import xc_ctrl_pkg::*;
#(
  parameter int unsigned TICK_WIDTH     = XC_TICK_WIDTH,
  parameter int unsigned CLEAR_CYCLES   = XC_CLEAR_CYCLES,
  parameter int unsigned FREEZE_CYCLES  = XC_FREEZE_CYCLES,
  parameter int unsigned TIMEOUT_CYCLES = XC_TIMEOUT_CYCLES,
  parameter int unsigned WINDOW_WIDTH   = XC_WINDOW_WIDTH
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    smp_tick,
  input  logic                    start,
  input  logic                    stop,
  input  logic                    cfg_valid,
  input  logic [TICK_WIDTH-1:0]   cfg_integration,
  input  logic [7:0]              cfg_order,
  input  logic                    clear_flags,
  input  logic                    readout_ack,
  output logic                    corr_reset,
  output logic                    corr_enable,
  output logic [7:0]              corr_order,
  output logic                    readout_req,
  output logic [WINDOW_WIDTH-1:0] window_count,
  output logic                    timeout_flag,
  output logic                    busy
);

  localparam int unsigned PH_MAX = (CLEAR_CYCLES > FREEZE_CYCLES) ? CLEAR_CYCLES : FREEZE_CYCLES;
  localparam int unsigned PH_W   = xc_cnt_width(PH_MAX);
  localparam int unsigned TO_W   = xc_cnt_width(TIMEOUT_CYCLES);

  xc_state_e               r_state;
  xc_state_e               w_next;
  logic                    r_corr_reset, r_corr_enable, r_req, r_busy, r_timeout_flag;
  logic [TICK_WIDTH-1:0]   r_sh_int, r_act_int, r_tick;
  logic [7:0]              r_sh_order, r_act_order;
  logic                    r_stop_pending;
  logic [WINDOW_WIDTH-1:0] r_window;
  logic [TICK_WIDTH-1:0]   w_tick_inc;
  logic                    w_ack, w_timeout, w_state_chg, w_ph_tc, w_to_tc;
  logic [PH_W-1:0]         w_ph_load;

  assign w_tick_inc  = r_tick + TICK_WIDTH'(1);
  assign w_state_chg = (w_next != r_state);
  assign w_ph_load   = (w_next == ST_CLEAR) ? PH_W'(CLEAR_CYCLES - 1) : PH_W'(FREEZE_CYCLES - 1);

  xc_cycle_counter #(.WIDTH(PH_W)) u_phase_cnt (
    .clk          (clk),
    .reset        (reset),
    .i_load       (w_state_chg),
    .i_load_value (w_ph_load),
    .i_dec        (1'b1),
    .o_tc         (w_ph_tc)
  );

  xc_cycle_counter #(.WIDTH(TO_W)) u_timeout_cnt (
    .clk          (clk),
    .reset        (reset),
    .i_load       (w_state_chg),
    .i_load_value (TO_W'(TIMEOUT_CYCLES - 1)),
    .i_dec        (r_state == ST_READOUT),
    .o_tc         (w_to_tc)
  );

  always_comb begin
    w_next    = r_state;
    w_ack     = 1'b0;
    w_timeout = 1'b0;
    case (r_state)
      ST_IDLE:      if (start && !stop) w_next = ST_CLEAR;
      ST_CLEAR:     if (w_ph_tc) w_next = ST_INTEGRATE;
      ST_INTEGRATE: if (smp_tick && (w_tick_inc == r_act_int)) w_next = ST_FREEZE;
      ST_FREEZE:    if (w_ph_tc) w_next = ST_READOUT;
      ST_READOUT: begin
        if (readout_ack) w_ack = 1'b1;
        else if (w_to_tc) w_timeout = 1'b1;
        // A stop arriving in the closing cycle itself still ends the run here.
        if (w_ack || w_timeout) w_next = (r_stop_pending || stop) ? ST_IDLE : ST_CLEAR;
      end
      default:      w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= ST_IDLE;
      r_corr_reset   <= 1'b1;
      r_corr_enable  <= 1'b0;
      r_req          <= 1'b0;
      r_busy         <= 1'b0;
      r_timeout_flag <= 1'b0;
      r_sh_int       <= TICK_WIDTH'(1);
      r_act_int      <= TICK_WIDTH'(1);
      r_sh_order     <= '0;
      r_act_order    <= '0;
      r_tick         <= '0;
      r_stop_pending <= 1'b0;
      r_window       <= '0;
    end else begin
      r_state       <= w_next;
      r_corr_reset  <= (w_next == ST_IDLE) || (w_next == ST_CLEAR);
      r_corr_enable <= (w_next == ST_INTEGRATE);
      r_req         <= (w_next == ST_READOUT);
      r_busy        <= (w_next != ST_IDLE);

      if (cfg_valid) begin
        r_sh_int   <= cfg_integration;
        r_sh_order <= cfg_order;
      end
      if ((w_next == ST_CLEAR) && (r_state != ST_CLEAR)) begin
        r_act_int   <= (r_sh_int == '0) ? TICK_WIDTH'(1) : r_sh_int;
        r_act_order <= r_sh_order;
      end

      if (r_state == ST_CLEAR) r_tick <= '0;
      else if ((r_state == ST_INTEGRATE) && smp_tick) r_tick <= w_tick_inc;

      if (w_next == ST_IDLE) r_stop_pending <= 1'b0;
      else if (stop && (r_state != ST_IDLE)) r_stop_pending <= 1'b1;

      if (w_ack) r_window <= r_window + WINDOW_WIDTH'(1);

      if (w_timeout) r_timeout_flag <= 1'b1;
      else if (clear_flags) r_timeout_flag <= 1'b0;
    end
  end

  assign corr_reset   = r_corr_reset;
  assign corr_enable  = r_corr_enable;
  assign corr_order   = r_act_order;
  assign readout_req  = r_req;
  assign window_count = r_window;
  assign timeout_flag = r_timeout_flag;
  assign busy         = r_busy;

endmodule

// File: tb/tb_correlator_integration_ctrl.sv
// Self-checking bench: per-cycle reference-model scoreboard, a table of
// single-window scenarios, and directed multi-cycle corner cases.
module tb_correlator_integration_ctrl;

  localparam int unsigned T_CLR = 2;
  localparam int unsigned T_FRZ = 2;
  localparam int unsigned T_TO  = 8;

  localparam int M_IDLE = 0, M_CLR = 1, M_INT = 2, M_FRZ = 3, M_RD = 4;

  logic        clk = 1'b0;
  logic        reset, smp_tick, start, stop, cfg_valid, clear_flags, readout_ack;
  logic [31:0] cfg_integration;
  logic [7:0]  cfg_order;
  logic        corr_reset, corr_enable, readout_req, timeout_flag, busy;
  logic [7:0]  corr_order;
  logic [15:0] window_count;

  correlator_integration_ctrl #(
    .TICK_WIDTH     (32),
    .CLEAR_CYCLES   (T_CLR),
    .FREEZE_CYCLES  (T_FRZ),
    .TIMEOUT_CYCLES (T_TO),
    .WINDOW_WIDTH   (16)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .smp_tick        (smp_tick),
    .start           (start),
    .stop            (stop),
    .cfg_valid       (cfg_valid),
    .cfg_integration (cfg_integration),
    .cfg_order       (cfg_order),
    .clear_flags     (clear_flags),
    .readout_ack     (readout_ack),
    .corr_reset      (corr_reset),
    .corr_enable     (corr_enable),
    .corr_order      (corr_order),
    .readout_req     (readout_req),
    .window_count    (window_count),
    .timeout_flag    (timeout_flag),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int n_print  = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      if (n_print < 40) begin
        n_print++;
        $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
      end
    end
  endtask

  // Reference model state
  int          m_state, m_cnt;
  logic [31:0] m_tick, m_int_sh, m_int_act;
  logic [7:0]  m_ord_sh, m_ord_act;
  logic        m_stop, m_to;
  logic [15:0] m_win;

  // Stimulus knobs (pulses are cleared after each cycle)
  logic        g_reset, g_start, g_stop, g_cfgv, g_clr;
  logic [31:0] g_int;
  logic [7:0]  g_ord;
  int          g_k, tick_per, ack_dly;

  logic [28:0] exp_q[$];

  function automatic logic [28:0] model_outs();
    return {(m_state == M_IDLE) || (m_state == M_CLR), m_state == M_INT, m_ord_act,
            m_state == M_RD, m_win, m_to, m_state != M_IDLE};
  endfunction

  task automatic model_step(input logic tk, input logic ak);
    int  n;
    logic a, t;
    if (g_reset) begin
      m_state = M_IDLE; m_cnt = 0; m_tick = 0; m_int_sh = 1; m_int_act = 1;
      m_ord_sh = 0; m_ord_act = 0; m_stop = 0; m_to = 0; m_win = 0;
      return;
    end
    n = m_state; a = 0; t = 0;
    case (m_state)
      M_IDLE: if (g_start && !g_stop) n = M_CLR;
      M_CLR:  if (m_cnt + 1 == T_CLR) n = M_INT;
      M_INT:  if (tk && (m_tick + 1 == m_int_act)) n = M_FRZ;
      M_FRZ:  if (m_cnt + 1 == T_FRZ) n = M_RD;
      default: begin
        if (ak) a = 1;
        else if (m_cnt + 1 == T_TO) t = 1;
        if (a || t) n = (m_stop || g_stop) ? M_IDLE : M_CLR;
      end
    endcase
    if (n == M_CLR && m_state != M_CLR) begin
      m_int_act = (m_int_sh == 0) ? 32'd1 : m_int_sh;
      m_ord_act = m_ord_sh;
    end
    if (g_cfgv) begin m_int_sh = g_int; m_ord_sh = g_ord; end
    if (m_state == M_CLR) m_tick = 0;
    else if (m_state == M_INT && tk) m_tick = m_tick + 1;
    if (n == M_IDLE) m_stop = 0;
    else if (g_stop && m_state != M_IDLE) m_stop = 1;
    if (a) m_win = m_win + 1;
    if (t) m_to = 1;
    else if (g_clr) m_to = 0;
    m_cnt   = (n != m_state) ? 0 : m_cnt + 1;
    m_state = n;
  endtask

  task automatic cyc();
    logic tk, ak;
    logic [28:0] e;
    tk = (tick_per > 0) && ((g_k % tick_per) == tick_per - 1);
    ak = (m_state == M_RD) && (ack_dly >= 0) && (m_cnt == ack_dly);
    reset = g_reset; start = g_start; stop = g_stop; cfg_valid = g_cfgv;
    cfg_integration = g_int; cfg_order = g_ord; clear_flags = g_clr;
    smp_tick = tk; readout_ack = ak;
    model_step(tk, ak);
    exp_q.push_back(model_outs());
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk("cycle_outputs", {3'b0, corr_reset, corr_enable, corr_order, readout_req,
                          window_count, timeout_flag, busy}, {3'b0, e});
    g_reset = 0; g_start = 0; g_stop = 0; g_cfgv = 0; g_clr = 0;
    g_k++;
  endtask

  typedef struct {
    logic [31:0] cfg_int;
    logic [7:0]  order;
    int          per;
    int          ack;
    logic [15:0] exp_win;
    logic        exp_to;
  } scen_t;

  scen_t scen[5];

  initial begin
    int i, n_clr, n_en, n_frz, n_req, bad;
    g_reset = 1; g_start = 0; g_stop = 0; g_cfgv = 0; g_clr = 0;
    g_int = 0; g_ord = 0; g_k = 0; tick_per = 0; ack_dly = -1;
    m_state = M_IDLE; m_cnt = 0;
    cyc();
    chk("reset_corr_reset", {31'b0, corr_reset}, 32'd1);
    chk("reset_busy", {31'b0, busy}, 32'd0);
    chk("reset_req", {31'b0, readout_req}, 32'd0);
    chk("reset_order", {24'b0, corr_order}, 32'd0);

    // Single windows ended by an early stop; ack 7 lands on the timeout cycle.
    scen[0] = '{32'd1, 8'h11, 1, 0,  16'd1, 1'b0};
    scen[1] = '{32'd3, 8'h22, 2, 2,  16'd1, 1'b0};
    scen[2] = '{32'd2, 8'h33, 1, -1, 16'd0, 1'b1};
    scen[3] = '{32'd0, 8'h44, 4, 7,  16'd1, 1'b0};
    scen[4] = '{32'd5, 8'h55, 1, 3,  16'd1, 1'b0};
    for (int unsigned s = 0; s < 5; s++) begin
      g_reset = 1; cyc();
      g_cfgv = 1; g_int = scen[s].cfg_int; g_ord = scen[s].order; cyc();
      tick_per = scen[s].per; ack_dly = scen[s].ack;
      g_start = 1; g_k = 0; cyc();
      g_stop = 1; cyc();
      for (i = 0; i < 200 && busy; i++) cyc();
      chk("scen_idle", {31'b0, busy}, 32'd0);
      chk("scen_window", {16'b0, window_count}, {16'b0, scen[s].exp_win});
      chk("scen_timeout", {31'b0, timeout_flag}, {31'b0, scen[s].exp_to});
      chk("scen_order", {24'b0, corr_order}, {24'b0, scen[s].order});
    end

    // Basic window: N=4, tick every 3rd cycle, ack 5 cycles into READOUT.
    g_reset = 1; cyc();
    g_cfgv = 1; g_int = 4; g_ord = 8'hA5; cyc();
    tick_per = 3; ack_dly = 5;
    g_start = 1; g_k = 0; cyc();
    n_clr = 0; n_en = 0; n_frz = 0; n_req = 0;
    for (i = 0; i < 100 && window_count == 0; i++) begin
      if (corr_reset && busy) n_clr++;
      if (corr_enable) n_en++;
      if (busy && !corr_reset && !corr_enable && !readout_req) n_frz++;
      if (readout_req) n_req++;
      cyc();
    end
    chk("t1_clear_cycles", n_clr, 2);
    chk("t1_enable_cycles", n_en, 12);
    chk("t1_freeze_cycles", n_frz, 2);
    chk("t1_req_cycles", n_req, 6);
    chk("t1_window", {16'b0, window_count}, 32'd1);
    chk("t1_next_clear", {30'b0, corr_reset, busy}, 32'd3);

    // Config change mid-INTEGRATE only applies at the next CLEAR entry.
    for (i = 0; i < 50 && !corr_enable; i++) cyc();
    g_cfgv = 1; g_int = 0; g_ord = 8'd3; cyc();
    bad = 0;
    for (i = 0; i < 100 && window_count == 1; i++) begin
      if (corr_order != 8'hA5) bad++;
      cyc();
    end
    chk("t2_order_held", bad, 0);
    chk("t2_order_new", {24'b0, corr_order}, 32'd3);
    tick_per = 1;
    n_en = 0;
    for (i = 0; i < 100 && window_count == 2; i++) begin
      if (corr_enable) n_en++;
      cyc();
    end
    chk("t2_zero_len_is_one", n_en, 1);

    // Stop during INTEGRATE completes the window, then idles.
    for (i = 0; i < 50 && !corr_enable; i++) cyc();
    g_stop = 1; cyc();
    for (i = 0; i < 100 && busy; i++) cyc();
    chk("t3_window", {16'b0, window_count}, 32'd4);
    chk("t3_idle", {29'b0, busy, readout_req, corr_reset}, 32'd1);

    // Readout timeout with no ack.
    ack_dly = -1;
    g_start = 1; g_k = 0; cyc();
    for (i = 0; i < 100 && !readout_req; i++) cyc();
    n_req = 0;
    for (i = 0; i < 50 && readout_req; i++) begin n_req++; cyc(); end
    chk("t4_req_cycles", n_req, 8);
    chk("t4_flag", {31'b0, timeout_flag}, 32'd1);
    chk("t4_window", {16'b0, window_count}, 32'd4);
    chk("t4_next_clear", {30'b0, corr_reset, busy}, 32'd3);
    ack_dly = 0;
    g_stop = 1; cyc();
    for (i = 0; i < 100 && busy; i++) cyc();
    chk("t4_flag_sticky", {31'b0, timeout_flag}, 32'd1);
    chk("t4_window_after", {16'b0, window_count}, 32'd5);
    g_clr = 1; cyc();
    chk("t4_flag_cleared", {31'b0, timeout_flag}, 32'd0);

    // Ack on the same cycle the timeout would fire.
    ack_dly = 7;
    g_start = 1; g_k = 0; cyc();
    g_stop = 1; cyc();
    for (i = 0; i < 100 && busy; i++) cyc();
    chk("t5_window", {16'b0, window_count}, 32'd6);
    chk("t5_flag", {31'b0, timeout_flag}, 32'd0);

    // Reset in READOUT aborts the handshake; start+stop together stays idle.
    ack_dly = -1;
    g_start = 1; g_k = 0; cyc();
    for (i = 0; i < 100 && !readout_req; i++) cyc();
    cyc(); cyc();
    g_reset = 1; cyc();
    chk("t6_corr_reset", {31'b0, corr_reset}, 32'd1);
    chk("t6_req", {31'b0, readout_req}, 32'd0);
    chk("t6_window", {16'b0, window_count}, 32'd0);
    chk("t6_busy", {31'b0, busy}, 32'd0);
    g_start = 1; g_stop = 1; cyc();
    bad = 0;
    for (i = 0; i < 4; i++) begin if (busy) bad++; cyc(); end
    chk("t6_start_stop_idle", bad, 0);
    g_stop = 1; cyc();
    ack_dly = 0;
    g_start = 1; g_k = 0; cyc();
    for (i = 0; i < 100 && window_count == 0; i++) cyc();
    chk("t6_lone_stop_ignored", {31'b0, busy}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
